// File: rtl/gamma_pkg.sv
// Shared parameters, FSM state type and the default inverse-gamma curve
// generator for the gamma_inv_stream block.
package gamma_pkg;

  localparam int DATA_W    = 8;
  localparam int LUT_DEPTH = 256;
  localparam int LATENCY   = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // round(max*(x/max)^(1/0.6)) == round(cbrt(x^5 / max^2)); the result is the
  // largest y with (2y-1)^3 * max^2 <= 8 * x^5, found one bit at a time.
  function automatic int gamma_inv_value(input int x, input int max_val, input int width);
    longint lhs;
    longint m2;
    longint xl;
    longint y;
    longint t;
    xl  = longint'(x);
    lhs = 64'sd8 * xl * xl * xl * xl * xl;
    m2  = longint'(max_val) * longint'(max_val);
    y   = 0;
    for (int b = width - 1; b >= 0; b--) begin
      t = y | (64'sd1 << b);
      if ((2 * t - 1) * (2 * t - 1) * (2 * t - 1) * m2 <= lhs) begin
        y = t;
      end
    end
    return int'(y);
  endfunction

endpackage

// File: rtl/gamma_inv_rom.sv
// Combinational default curve: addr -> round(max*(addr/max)^(1/0.6)),
// folded to constants at elaboration.
module gamma_inv_rom #(
  parameter int DATA_W    = gamma_pkg::DATA_W,
  parameter int LUT_DEPTH = gamma_pkg::LUT_DEPTH
) (
  input  logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  import gamma_pkg::*;

  logic [DATA_W-1:0] curve [LUT_DEPTH];

  for (genvar a = 0; a < LUT_DEPTH; a++) begin : g_curve
    localparam int VALUE = gamma_inv_value(a, LUT_DEPTH - 1, DATA_W);
    assign curve[a] = DATA_W'(VALUE);
  end

  assign data = curve[addr];

endmodule

// File: rtl/gamma_inv_stream.sv
// Two-stage video pipeline that linearises gamma-encoded RGB through three
// identical writable tables, loaded from the default curve after every reset.
module gamma_inv_stream #(
  parameter int DATA_W    = gamma_pkg::DATA_W,
  parameter int LUT_DEPTH = gamma_pkg::LUT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_href,
  input  logic              pre_frame_de,
  input  logic [DATA_W-1:0] pre_img_r,
  input  logic [DATA_W-1:0] pre_img_g,
  input  logic [DATA_W-1:0] pre_img_b,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_de,
  output logic [DATA_W-1:0] post_img_r,
  output logic [DATA_W-1:0] post_img_g,
  output logic [DATA_W-1:0] post_img_b,
  input  logic              bypass_en,
  input  logic              cfg_wr_en,
  input  logic [DATA_W-1:0] cfg_wr_addr,
  input  logic [DATA_W-1:0] cfg_wr_data,
  output logic              cfg_ready,
  output logic              init_done
);
  import gamma_pkg::*;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] init_addr_q, init_addr_d;
  logic [DATA_W-1:0] rom_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wa, ram_wd;

  logic              s1_vsync, s1_href, s1_de, s1_bypass;
  logic [DATA_W-1:0] s1_r, s1_g, s1_b;

  logic [DATA_W-1:0] lut_r [LUT_DEPTH];
  logic [DATA_W-1:0] lut_g [LUT_DEPTH];
  logic [DATA_W-1:0] lut_b [LUT_DEPTH];

  gamma_inv_rom #(
    .DATA_W    (DATA_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_rom (
    .addr (init_addr_q),
    .data (rom_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    ram_we      = 1'b0;
    ram_wa      = cfg_wr_addr;
    ram_wd      = cfg_wr_data;
    unique case (state_q)
      ST_INIT: begin
        ram_we      = 1'b1;
        ram_wa      = init_addr_q;
        ram_wd      = rom_data;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == DATA_W'(LUT_DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  ram_we = cfg_wr_en;
      default: state_d = ST_INIT;
    endcase
  end

  assign init_done = (state_q == ST_RUN);
  assign cfg_ready = init_done;

  // NOTE: the tables carry no reset; the INIT sweep rewrites every entry
  // after each reset, which keeps them mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      lut_r[ram_wa] <= ram_wd;
      lut_g[ram_wa] <= ram_wd;
      lut_b[ram_wa] <= ram_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vsync  <= 1'b0;
      s1_href   <= 1'b0;
      s1_de     <= 1'b0;
      s1_bypass <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
    end else begin
      s1_vsync  <= pre_frame_vsync;
      s1_href   <= pre_frame_href;
      s1_de     <= pre_frame_de;
      s1_bypass <= bypass_en;
      s1_r      <= pre_img_r;
      s1_g      <= pre_img_g;
      s1_b      <= pre_img_b;
    end
  end

  // Table reads sample the entries before any same-edge write lands, so a
  // colliding write is only seen by the following read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_de    <= 1'b0;
      post_img_r       <= '0;
      post_img_g       <= '0;
      post_img_b       <= '0;
    end else begin
      post_frame_vsync <= s1_vsync;
      post_frame_href  <= 1'b0;
      post_frame_de    <= 1'b0;
      post_img_r       <= '0;
      post_img_g       <= '0;
      post_img_b       <= '0;
      if (state_q == ST_RUN) begin
        post_frame_href <= s1_href;
        post_frame_de   <= s1_de;
        if (s1_de) begin
          post_img_r <= s1_bypass ? s1_r : lut_r[s1_r];
          post_img_g <= s1_bypass ? s1_g : lut_g[s1_g];
          post_img_b <= s1_bypass ? s1_b : lut_b[s1_b];
        end
      end
    end
  end

endmodule
